// File: rtl/adder_4_ripple_carry.sv
// rtl/adder_4_ripple_carry.sv - registered 4-bit ripple-carry adder built from 1-bit full-adder cells
// Outputs are loaded only on valid operations and are held otherwise.

module adder_4_ripple_carry_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module adder_4_ripple_carry (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       in_valid,
   output logic [3:0] sum,
   output logic       cout,
   output logic       ovf,
   output logic       zero,
   output logic       out_valid
);

   logic [4:0] w_c;
   logic [3:0] w_sum;
   logic       w_ovf;
   logic       w_zero;

   logic [3:0] r_sum;
   logic       r_cout;
   logic       r_ovf;
   logic       r_zero;
   logic       r_out_valid;

   assign w_c[0] = cin;

   // Strict ripple chain: each cell's carry-out drives the next cell's carry-in.
   for (genvar gi = 0; gi < 4; gi++) begin : g_cell
      adder_4_ripple_carry_fa u_fa (
         .i_a (a[gi]),
         .i_b (b[gi]),
         .i_c (w_c[gi]),
         .o_s (w_sum[gi]),
         .o_c (w_c[gi+1])
      );
   end

   assign w_ovf  = w_c[3] ^ w_c[4];
   assign w_zero = (w_sum == 4'b0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum       <= 4'b0000;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_c[4];
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
         end
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_4_ripple_carry.sv
// tb/tb_adder_4_ripple_carry.sv - self-checking bench for adder_4_ripple_carry
// Reference model is plain integer arithmetic on the operands.

module tb_adder_4_ripple_carry;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       in_valid;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;
   logic       zero;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_sum  = 4'b0000;
   logic       exp_cout = 1'b0;
   logic       exp_ovf  = 1'b0;
   logic       exp_zero = 1'b1;
   logic       exp_ov   = 1'b0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t table_v[9];

   adder_4_ripple_carry dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check_model(input string tag);
      checks++;
      assert (sum === exp_sum) else begin
         errors++;
         $error("FAIL %s sum observed=%b expected=%b", tag, sum, exp_sum);
      end
      checks++;
      assert (cout === exp_cout) else begin
         errors++;
         $error("FAIL %s cout observed=%b expected=%b", tag, cout, exp_cout);
      end
      checks++;
      assert (ovf === exp_ovf) else begin
         errors++;
         $error("FAIL %s ovf observed=%b expected=%b", tag, ovf, exp_ovf);
      end
      checks++;
      assert (zero === exp_zero) else begin
         errors++;
         $error("FAIL %s zero observed=%b expected=%b", tag, zero, exp_zero);
      end
      checks++;
      assert (out_valid === exp_ov) else begin
         errors++;
         $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_ov);
      end
   endtask

   // Drive one cycle, advance the model, then compare just after the edge.
   task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic tv, input logic trst, input string tag);
      int u;
      int s;
      a        = ta;
      b        = tb;
      cin      = tc;
      in_valid = tv;
      rst      = trst;
      @(posedge clk);
      #1;
      if (trst) begin
         exp_sum  = 4'b0000;
         exp_cout = 1'b0;
         exp_ovf  = 1'b0;
         exp_zero = 1'b1;
         exp_ov   = 1'b0;
      end else begin
         exp_ov = tv;
         if (tv) begin
            u        = int'(ta) + int'(tb) + int'(tc);
            s        = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
            exp_sum  = 4'(u % 16);
            exp_cout = (u >= 16);
            exp_zero = ((u % 16) == 0);
            exp_ovf  = (s > 7) || (s < -8);
         end
      end
      check_model(tag);
   endtask

   task automatic check_const(input string tag, input logic [3:0] s, input logic co,
                              input logic ov);
      checks++;
      assert ({cout, sum, ovf, zero} === {co, s, ov, (s == 4'b0000)}) else begin
         errors++;
         $error("FAIL %s {cout,sum,ovf,zero} observed=%b_%b_%b_%b expected=%b_%b_%b_%b",
                tag, cout, sum, ovf, zero, co, s, ov, (s == 4'b0000));
      end
   endtask

   initial begin
      table_v[0] = '{4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0};
      table_v[1] = '{4'b0010, 4'b0001, 1'b1, 4'b0100, 1'b0, 1'b0};
      table_v[2] = '{4'b1010, 4'b0111, 1'b0, 4'b0001, 1'b1, 1'b0};
      table_v[3] = '{4'b0011, 4'b0101, 1'b1, 4'b1001, 1'b0, 1'b1};
      table_v[4] = '{4'b1010, 4'b1001, 1'b0, 4'b0011, 1'b1, 1'b1};
      table_v[5] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1};
      table_v[6] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
      table_v[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
      table_v[8] = '{4'b0001, 4'b1110, 1'b0, 4'b1111, 1'b0, 1'b0};

      rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;

      // Reset with arbitrary valid inputs
      for (int i = 0; i < 2; i++)
         step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1, "reset");

      // Directed table, back to back
      for (int i = 0; i < 9; i++) begin
         step(table_v[i].a, table_v[i].b, table_v[i].c, 1'b1, 1'b0, $sformatf("table%0d", i));
         check_const($sformatf("table%0d_const", i), table_v[i].s, table_v[i].co, table_v[i].ov);
      end

      // Hold: outputs keep 1100+1100+1 while in_valid is low
      step(4'b1100, 4'b1100, 1'b1, 1'b1, 1'b0, "hold_load");
      for (int i = 0; i < 3; i++) begin
         step(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, $sformatf("hold%0d", i));
         check_const($sformatf("hold%0d_const", i), 4'b1001, 1'b1, 1'b0);
      end

      // 15 consecutive random vectors
      for (int i = 0; i < 15; i++)
         step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b0, $sformatf("b2b%0d", i));

      // Reset on the same edge as a valid operation
      step(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, "rst_with_valid");
      step(4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0, "resume");

      // Exhaustive sweep
      for (int i = 0; i < 512; i++)
         step(4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1, 1'b0, $sformatf("exh%0d", i));

      // Random mix of valid, idle and reset cycles
      for (int i = 0; i < 200; i++)
         step(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 15) == 0), $sformatf("mix%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
